// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage with load-data handshake, load alignment and writeback/forwarding buses.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 80,
   parameter int MEM_TO_WB_WD = 70,
   parameter int STALL_W      = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_W-1:0]      stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic                    data_sram_rvalid,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [37:0]             mem_to_id,
   output logic                    stallreq_from_mem,
   output logic                    mem_load_pending
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
   state_e                  state_q, state_d;
   logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
   logic [31:0]             rdata_buf_q, rdata_buf_d, load_word, rf_wdata;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic [3:0]              mem_op;
   logic                    advance, bubble, reload, is_load, next_is_load, capture;
   logic                    unused_stall;

   assign unused_stall = ^{stall[2:0], stall[STALL_W-1:5]};

   always_comb begin
      advance      = ~stall[3];
      bubble       = stall[3] & ~stall[4];
      reload       = advance | bubble;
      bus_d        = bubble ? '0 : (advance ? ex_to_mem_bus : bus_q);
      is_load      = bus_q[43] & (bus_q[42:39] == 4'd0) & bus_q[38];
      next_is_load = bus_d[43] & (bus_d[42:39] == 4'd0) & bus_d[38];
      // a register advance wins over a simultaneous capture
      capture      = ~reload & (state_q == WAIT) & data_sram_rvalid;
      state_d      = reload ? (next_is_load ? WAIT : IDLE) : (capture ? DONE : state_q);
      rdata_buf_d  = capture ? data_sram_rdata : rdata_buf_q;
      load_word    = (state_q == DONE) ? rdata_buf_q : data_sram_rdata;
      mem_op       = bus_q[79:76];
      ld_byte      = 8'(load_word >> {bus_q[1:0], 3'b000});
      ld_half      = bus_q[1] ? load_word[31:16] : load_word[15:0];
      rf_wdata     = !is_load      ? bus_q[31:0] :
                     mem_op == 4'd1 ? {{24{ld_byte[7]}}, ld_byte} :
                     mem_op == 4'd2 ? {24'd0, ld_byte} :
                     mem_op == 4'd3 ? {{16{ld_half[15]}}, ld_half} :
                     mem_op == 4'd4 ? {16'd0, ld_half} : load_word;
      mem_to_wb_bus     = {bus_q[75:44], bus_q[37], bus_q[36:32], rf_wdata};
      mem_to_id         = {bus_q[37], bus_q[36:32], rf_wdata};
      stallreq_from_mem = (state_q == WAIT) & ~data_sram_rvalid;
      mem_load_pending  = stallreq_from_mem;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_q       <= '0;
         state_q     <= IDLE;
         rdata_buf_q <= '0;
      end else begin
         bus_q       <= bus_d;
         state_q     <= state_d;
         rdata_buf_q <= rdata_buf_d;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [5:0]  stall = '0;
   logic [79:0] ex_to_mem_bus = '0;
   logic        data_sram_rvalid = 1'b0;
   logic [31:0] data_sram_rdata = '0;
   logic [69:0] mem_to_wb_bus;
   logic [37:0] mem_to_id;
   logic        stallreq_from_mem, mem_load_pending;
   int          n_chk = 0, n_fail = 0;
   logic [79:0] cur = '0;
   logic        got = 1'b0;
   logic [31:0] buf_m = '0;

   mem_stage dut (
      .clk(clk), .resetn(resetn), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
      .data_sram_rvalid(data_sram_rvalid), .data_sram_rdata(data_sram_rdata),
      .mem_to_wb_bus(mem_to_wb_bus), .mem_to_id(mem_to_id),
      .stallreq_from_mem(stallreq_from_mem), .mem_load_pending(mem_load_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [69:0] got_v, input logic [69:0] exp_v);
      n_chk++;
      if (got_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   function automatic logic [79:0] mk(input logic [3:0] op, input logic [31:0] pc, input logic en,
                                      input logic [3:0] wen, input logic sel, input logic we,
                                      input logic [4:0] wa, input logic [31:0] res);
      return {op, pc, en, wen, sel, we, wa, res};
   endfunction

   function automatic logic ld(input logic [79:0] e);
      return e[43] && e[42:39] == 4'd0 && e[38];
   endfunction

   function automatic logic [31:0] align(input logic [3:0] op, input logic [1:0] a, input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * int'(a)));
      h = 16'(w >> (16 * int'(a[1])));
      case (op)
         4'd1: return 32'($signed(b));
         4'd2: return {24'd0, b};
         4'd3: return 32'($signed(h));
         4'd4: return {16'd0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [69:0] exp_wb();
      logic [31:0] w;
      w = got ? buf_m : data_sram_rdata;
      return {cur[75:44], cur[37], cur[36:32], ld(cur) ? align(cur[79:76], cur[1:0], w) : cur[31:0]};
   endfunction

   task automatic drive(input logic [79:0] b, input logic [5:0] s, input logic rv, input logic [31:0] rd);
      logic [69:0] e;
      ex_to_mem_bus = b;
      stall = s;
      data_sram_rvalid = rv;
      data_sram_rdata = rd;
      #2;
      e = exp_wb();
      check("m_wb", mem_to_wb_bus, e);
      check("m_id", mem_to_id, e[37:0]);
      check("m_stallreq", stallreq_from_mem, ld(cur) && !got && !rv);
      check("m_pending", mem_load_pending, ld(cur) && !got && !rv);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!stall[3]) begin
         cur = ex_to_mem_bus;
         got = 1'b0;
      end else if (!stall[4]) begin
         cur = '0;
         got = 1'b0;
      end else if (ld(cur) && !got && data_sram_rvalid) begin
         got = 1'b1;
         buf_m = data_sram_rdata;
      end
      #1;
   endtask

   task automatic ld_case(input string tag, input logic [3:0] op, input logic [1:0] a, input logic [31:0] ev);
      drive(mk(op, 32'h1000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, {30'h100, a}), 6'd0, 1'b0, 32'd0);
      tick();
      drive('0, 6'd0, 1'b1, 32'h80FF7F01);
      check(tag, mem_to_wb_bus[31:0], ev);
      check({tag, "_sr"}, stallreq_from_mem, 1'b0);
      tick();
   endtask

   initial begin
      logic [79:0] lw_op;
      logic [5:0]  s;
      lw_op = mk(4'd5, 32'h2000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h0000_0100);
      #1;
      check("rst_wb", mem_to_wb_bus, 70'd0);
      check("rst_id", mem_to_id, 38'd0);
      check("rst_sr", stallreq_from_mem, 1'b0);
      #12 resetn = 1'b1;
      tick();
      drive('0, 6'd0, 1'b0, 32'd0);
      check("rel_wb", mem_to_wb_bus, 70'd0);

      drive(mk(4'd0, 32'h400, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 6'd0, 1'b0, 32'd0);
      tick();
      drive('0, 6'd0, 1'b0, 32'd0);
      check("alu_wdata", mem_to_wb_bus[31:0], 32'h1234_5678);
      check("alu_waddr", mem_to_wb_bus[36:32], 5'd5);
      check("alu_sr", stallreq_from_mem, 1'b0);
      tick();

      ld_case("lb_a3", 4'd1, 2'd3, 32'hFFFF_FF80);
      ld_case("lbu_a3", 4'd2, 2'd3, 32'h0000_0080);
      ld_case("lb_a1", 4'd1, 2'd1, 32'h0000_007F);
      ld_case("lh_a2", 4'd3, 2'd2, 32'hFFFF_80FF);
      ld_case("lhu_a0", 4'd4, 2'd0, 32'h0000_7F01);
      ld_case("lw", 4'd5, 2'd2, 32'h80FF_7F01);
      ld_case("op7_lw", 4'd7, 2'd1, 32'h80FF_7F01);

      // three-cycle SRAM latency
      drive(lw_op, 6'd0, 1'b0, 32'd0);
      tick();
      drive('0, 6'b011000, 1'b0, 32'hCAFE_0001);
      check("lat_c1", stallreq_from_mem, 1'b1);
      tick();
      drive('0, 6'b011000, 1'b0, 32'hCAFE_0001);
      check("lat_c2", stallreq_from_mem, 1'b1);
      tick();
      drive('0, 6'd0, 1'b1, 32'hCAFE_0001);
      check("lat_c3", stallreq_from_mem, 1'b0);
      check("lat_data", mem_to_wb_bus[31:0], 32'hCAFE_0001);
      tick();

      drive(lw_op, 6'd0, 1'b0, 32'd0);
      tick();
      drive('0, 6'b011000, 1'b1, 32'hDEAD_BEEF);
      check("cap_data", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive('0, 6'b011000, 1'(i), 32'd0);
         check("hold_data", mem_to_wb_bus[31:0], 32'hDEAD_BEEF);
         check("hold_sr", stallreq_from_mem, 1'b0);
         tick();
      end
      drive('0, 6'd0, 1'b0, 32'd0);
      tick();

      drive(mk(4'd0, 32'h3000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, 32'h0000_ABCD), 6'd0, 1'b0, 32'd0);
      tick();
      drive('0, 6'b011000, 1'b0, 32'd0);
      tick();
      drive('0, 6'b011000, 1'b0, 32'd0);
      check("held_we", mem_to_wb_bus[37], 1'b1);
      check("held_wdata", mem_to_wb_bus[31:0], 32'h0000_ABCD);
      drive('0, 6'b001000, 1'b0, 32'd0);
      tick();
      drive('0, 6'b011000, 1'b0, 32'd0);
      check("bubble_wb", mem_to_wb_bus, 70'd0);
      check("bubble_id", mem_to_id, 38'd0);
      tick();

      // asynchronous reset while a load waits
      drive(lw_op, 6'd0, 1'b0, 32'd0);
      tick();
      drive('0, 6'b011000, 1'b0, 32'h55);
      check("rw_pre", stallreq_from_mem, 1'b1);
      #2 resetn = 1'b0;
      #1;
      check("rw_wb", mem_to_wb_bus, 70'd0);
      check("rw_id", mem_to_id, 38'd0);
      check("rw_sr", stallreq_from_mem, 1'b0);
      check("rw_pend", mem_load_pending, 1'b0);
      cur = '0;
      got = 1'b0;
      buf_m = '0;
      data_sram_rvalid = 1'b1;
      @(posedge clk);
      #3;
      check("rw_hold", mem_to_wb_bus, 70'd0);
      resetn = 1'b1;
      tick();
      drive('0, 6'b011000, 1'b1, 32'h55);
      check("rw_after", stallreq_from_mem, 1'b0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         s = 6'($urandom);
         s[3] = $urandom_range(0, 9) < 6;
         s[4] = $urandom_range(0, 3) != 0;
         drive(mk(4'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0, $urandom_range(0, 3) != 0,
                  1'($urandom), 5'($urandom), $urandom),
               s, $urandom_range(0, 9) < 4, $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, directly downstream of the execute stage. Latches the execute-to-memory bus, waits for data-SRAM read data using a valid handshake that may take zero or more cycles, and aligns and extends byte, halfword and word loads. Produces the memory-to-writeback bus and a forwarding bus to decode. Requests a pipeline stall while a load's read data is outstanding.

## Interface
Parameters:
- EX_TO_MEM_WD, 80, execute-to-memory bus width.
- MEM_TO_WB_WD, 70, memory-to-writeback bus width.
- STALL_W, 6, stall vector width. Bit k=1 means "stop" for pipeline register k.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- stall  in  STALL_W  pipeline stall vector from the stall controller.
- ex_to_mem_bus  in  80  fields: {mem_op[79:76], ex_pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- data_sram_rvalid  in  1  read data valid for the outstanding load.
- data_sram_rdata  in  32  read data word, little-endian.
- mem_to_wb_bus  out  70  fields: {mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id  out  38  fields: {rf_we, rf_waddr, rf_wdata}, used for forwarding.
- stallreq_from_mem  out  1  stall request to the stall controller.
- mem_load_pending  out  1  a load is in MEM and its data is not yet available.

## Operation
- **Pipeline register** (posedge clk, async clear on resetn=0):
  - If stall[3]=1 and stall[4]=0: load all-zero (bubble).
  - Else if stall[3]=0: load ex_to_mem_bus.
  - Else: hold.
- **Load condition**: is_load = data_ram_en & (data_ram_wen==0) & sel_rf_res, evaluated on the registered bus.
- **mem_op encoding**:
  - 0001 lb, 0010 lbu, 0011 lh, 0100 lhu, 0101 lw.
  - Any other value is treated as lw when is_load.
- **Alignment**: a = ex_result[1:0].
  - lb/lbu: select byte a (byte 0 = rdata[7:0]), then sign- or zero-extend to 32 bits.
  - lh/lhu: select halfword a[1] (0 → rdata[15:0]), then sign- or zero-extend; a[0] is ignored.
  - lw: full word; a is ignored.
- **Read data source**:
  - load_word = data_sram_rdata in state WAIT.
  - load_word = rdata_buf in state DONE.
- **Writeback value**: rf_wdata = is_load ? aligned(load_word) : ex_result.
  - rf_we, rf_waddr and mem_pc pass through from the register.
- **State machine** (state and rdata_buf are async-cleared to IDLE / 0):
  - IDLE: the register holds a non-load or a bubble.
  - WAIT: a load is in MEM with no data captured. If data_sram_rvalid=1: rdata_buf ← rdata, go to DONE.
  - DONE: data held in rdata_buf until the register advances.
  - Whenever the register loads a new entry or a bubble, next state = WAIT if the new entry is a load, else IDLE. This overrides every other transition.
  - When the register holds, WAIT→DONE on rvalid; DONE and IDLE are held.
- **Outputs**:
  - stallreq_from_mem = (state==WAIT) & ~data_sram_rvalid. This is combinational and carries no registered delay.
  - mem_load_pending = stallreq_from_mem.
  - mem_to_id carries the same rf_we/rf_waddr/rf_wdata as mem_to_wb_bus. Decode consults mem_load_pending before using rf_wdata.
- **Ignored rvalid**: data_sram_rvalid in IDLE or DONE has no effect.

## Timing
- **Reset values**: every output is 0 while resetn=0 and in the first cycle after release (register cleared, state IDLE).
- **Zero-wait SRAM**: rvalid is asserted in the first cycle the load occupies MEM.
  - rf_wdata is valid in that same cycle.
  - stallreq_from_mem is never asserted and no cycle is added.
- **N-cycle SRAM** (rvalid arrives in the N-th MEM cycle):
  - stallreq_from_mem is 1 for exactly N-1 cycles.
  - Data appears combinationally in cycle N.
  - The register advances at the end of cycle N, provided upstream stall bits clear.
- **Downstream stall after capture**: if stall[3] stays 1 after capture, the state holds DONE and rf_wdata stays constant from rdata_buf.
- **Simultaneous rvalid and register advance**: the advance wins. The new entry determines the next state, and the capture is discarded.
- **Reset mid-load**: resetn=0 in WAIT or DONE immediately clears state, buffer and outputs. rvalid arriving during reset is ignored.
- **Bubble while in WAIT**: pending data is abandoned, state goes to IDLE, and stallreq drops the next cycle.

## Test plan
- **Non-load pass-through**: ALU op with ex_result=0x1234_5678, rf_we=1, rf_waddr=5, stall=0 → next cycle mem_to_wb_bus rf_wdata=0x12345678, waddr=5, stallreq=0.
- **Byte/halfword alignment**, zero-wait, rdata=0x80FF_7F01:
  - lb a=3 → 0xFFFFFF80.
  - lbu a=3 → 0x00000080.
  - lb a=1 → 0x0000007F.
  - lh a=2 → 0xFFFF80FF.
  - lhu a=0 → 0x00007F01.
  - lw → 0x80FF7F01.
- **3-cycle latency lw**: rvalid asserted in the 3rd MEM cycle → stallreq=1 in cycles 1–2, 0 in cycle 3; rf_wdata=rdata in cycle 3.
- **Capture then hold**: rvalid with rdata=0xDEADBEEF while stall[3]=1 for 4 more cycles, rdata changed to 0 afterwards → rf_wdata stays 0xDEADBEEF, state DONE, stallreq=0.
- **Bubble insertion**: stall[3]=1, stall[4]=0 → next cycle rf_we=0 and bus all-zero; stall[3]=1, stall[4]=1 → contents held.
- **Reset mid-WAIT**: pull resetn low asynchronously mid-cycle → all outputs 0 immediately; after release the state is IDLE with no stallreq.
